// File: rtl/morra_pkg.sv
// Shared types for the Morra scoreboard: result codes, FSM states and the
// FIFO record layout (at the default round-counter width).
package morra_pkg;

    // Encoding shared by the game's manche and partita outputs
    typedef enum logic [1:0] {
        NONE = 2'b00,
        P1   = 2'b01,
        P2   = 2'b10,
        DRAW = 2'b11
    } morra_code_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } morra_state_e;

    localparam int unsigned REC_RW = 5;

    // One completed match as queued in the result FIFO: {code, rounds}
    typedef struct packed {
        morra_code_e         code;
        logic [REC_RW-1:0]   rounds;
    } morra_rec_t;

endpackage

// File: rtl/morra_result_fifo.sv
// Synchronous result FIFO with a registered head word.
// Ports:
//   clk, rst          clock, async active-high reset
//   push_i, wdata_i   write request and data (dropped when full without pop)
//   pop_i             remove head word (ignored when empty)
//   full_o, empty_o   registered occupancy flags
//   head_o            registered head word, 0 when empty
module morra_result_fifo #(
    parameter int unsigned W     = 7,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q, rptr_nx;
    logic [CNTW-1:0] count_q, count_d;
    logic            full_q, empty_q;
    logic [W-1:0]    head_q, head_d;
    logic            push_ok, pop_ok;

    // A push into a full FIFO is accepted only when the head leaves the same cycle
    assign pop_ok  = pop_i && !empty_q;
    assign push_ok = push_i && (!full_q || pop_ok);
    assign rptr_nx = rptr_q + AW'(1);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNTW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNTW'(1);
        end
    end

    // Next head: the following entry after a pop, the incoming word when it
    // lands in an empty (or just-emptied) FIFO, otherwise unchanged
    always_comb begin
        head_d = head_q;
        if (pop_ok) begin
            if (count_q == CNTW'(1)) begin
                head_d = push_ok ? wdata_i : '0;
            end else begin
                head_d = mem_q[rptr_nx];
            end
        end else if (empty_q && push_ok) begin
            head_d = wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            head_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_nx;
            end
            count_q <= count_d;
            full_q  <= (count_d == CNTW'(DEPTH));
            empty_q <= (count_d == '0);
            head_q  <= head_d;
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign head_o  = head_q;

endmodule

// File: rtl/morra_scoreboard.sv
// Match scoreboard downstream of the MorraCinese game core: counts rounds,
// keeps saturating match tallies and queues one record per finished match.
// Optional streak tracking is enabled with the MORRA_SCORE_STREAK_EN macro;
// without it streak_len/streak_who are tied to 0.
// Ports:
//   clk, rst                    clock, async active-high reset
//   inizia                      game start strobe (registered once internally)
//   manche, partita             game round / match result codes
//   wins_p1, wins_p2, ties      completed-match tallies
//   match_active                high while a match is in progress
//   rd_valid, rd_data, rd_ready result record handshake, {code, rounds}
//   overflow                    sticky, set when a record was dropped
//   streak_len, streak_who      consecutive-win streak
module morra_scoreboard
    import morra_pkg::*;
#(
    parameter int unsigned CW    = 8,
    parameter int unsigned RW    = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inizia,
    input  logic [1:0]    manche,
    input  logic [1:0]    partita,
    output logic [CW-1:0] wins_p1,
    output logic [CW-1:0] wins_p2,
    output logic [CW-1:0] ties,
    output logic          match_active,
    output logic          rd_valid,
    output logic [RW+1:0] rd_data,
    input  logic          rd_ready,
    output logic          overflow,
    output logic [CW-1:0] streak_len,
    output logic [1:0]    streak_who
);

    localparam logic [RW-1:0] RMAX = '1;
    localparam logic [CW-1:0] CMAX = '1;

    morra_state_e  state_q, state_d;
    logic          inizia_q;
    logic [RW-1:0] rounds_q, rounds_d;
    logic [CW-1:0] wins_p1_q, wins_p1_d;
    logic [CW-1:0] wins_p2_q, wins_p2_d;
    logic [CW-1:0] ties_q, ties_d;
    logic          overflow_q, overflow_d;
    logic          match_active_q;
    logic          round_ok, end_c, pop_c;
    logic          fifo_full, fifo_empty;
    logic [RW+1:0] push_data;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a start can end the match in the very same cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (inizia_q) begin
                    state_d = (partita != NONE) ? DONE : PLAY;
                end
            end
            PLAY: begin
                if (partita != NONE) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign round_ok = (manche != NONE);
    assign end_c    = (inizia_q || state_q == PLAY) && (partita != NONE);
    assign pop_c    = rd_ready && !fifo_empty;

    // Datapath outputs: round count, tallies, overflow
    always_comb begin
        rounds_d   = rounds_q;
        wins_p1_d  = wins_p1_q;
        wins_p2_d  = wins_p2_q;
        ties_d     = ties_q;
        overflow_d = overflow_q;
        if (inizia_q) begin
            rounds_d = round_ok ? RW'(1) : '0;
        end else if (state_q == PLAY && round_ok && rounds_q != RMAX) begin
            rounds_d = rounds_q + RW'(1);
        end
        if (end_c) begin
            unique case (partita)
                P1:      if (wins_p1_q != CMAX) wins_p1_d = wins_p1_q + CW'(1);
                P2:      if (wins_p2_q != CMAX) wins_p2_d = wins_p2_q + CW'(1);
                default: if (ties_q != CMAX) ties_d = ties_q + CW'(1);
            endcase
            if (fifo_full && !pop_c) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Record carries the round count including the ending round
    assign push_data = {partita, rounds_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inizia_q       <= 1'b0;
            rounds_q       <= '0;
            wins_p1_q      <= '0;
            wins_p2_q      <= '0;
            ties_q         <= '0;
            overflow_q     <= 1'b0;
            match_active_q <= 1'b0;
        end else begin
            inizia_q       <= inizia;
            rounds_q       <= rounds_d;
            wins_p1_q      <= wins_p1_d;
            wins_p2_q      <= wins_p2_d;
            ties_q         <= ties_d;
            overflow_q     <= overflow_d;
            match_active_q <= (state_d == PLAY);
        end
    end

`ifdef MORRA_SCORE_STREAK_EN
    logic [CW-1:0] streak_len_q, streak_len_d;
    logic [1:0]    streak_who_q, streak_who_d;

    // Same winner extends the streak, a new winner restarts it, a draw clears it
    always_comb begin
        streak_len_d = streak_len_q;
        streak_who_d = streak_who_q;
        if (end_c) begin
            if (partita == DRAW) begin
                streak_len_d = '0;
                streak_who_d = NONE;
            end else if (partita == streak_who_q) begin
                if (streak_len_q != CMAX) begin
                    streak_len_d = streak_len_q + CW'(1);
                end
            end else begin
                streak_who_d = partita;
                streak_len_d = CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_len_q <= '0;
            streak_who_q <= NONE;
        end else begin
            streak_len_q <= streak_len_d;
            streak_who_q <= streak_who_d;
        end
    end

    assign streak_len = streak_len_q;
    assign streak_who = streak_who_q;
`else
    assign streak_len = '0;
    assign streak_who = '0;
`endif

    morra_result_fifo #(
        .W     (RW + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (end_c),
        .wdata_i (push_data),
        .pop_i   (pop_c),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (rd_data)
    );

    assign wins_p1      = wins_p1_q;
    assign wins_p2      = wins_p2_q;
    assign ties         = ties_q;
    assign match_active = match_active_q;
    assign rd_valid     = !fifo_empty;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_morra_scoreboard.sv
// Directed self-checking bench for morra_scoreboard (CW=8, RW=5, DEPTH=4).
module tb_morra_scoreboard;
    import morra_pkg::*;

    localparam int unsigned CW    = 8;
    localparam int unsigned RW    = 5;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          inizia;
    logic [1:0]    manche;
    logic [1:0]    partita;
    logic          rd_ready;
    logic [CW-1:0] wins_p1, wins_p2, ties;
    logic          match_active;
    logic          rd_valid;
    logic [RW+1:0] rd_data;
    logic          overflow;
    logic [CW-1:0] streak_len;
    logic [1:0]    streak_who;

    int checks   = 0;
    int failures = 0;

    morra_scoreboard #(.CW(CW), .RW(RW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .inizia       (inizia),
        .manche       (manche),
        .partita      (partita),
        .wins_p1      (wins_p1),
        .wins_p2      (wins_p2),
        .ties         (ties),
        .match_active (match_active),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .overflow     (overflow),
        .streak_len   (streak_len),
        .streak_who   (streak_who)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected record word {code, rounds}
    function automatic logic [31:0] rec(input morra_code_e c, input int unsigned n);
        morra_rec_t r;
        r.code   = c;
        r.rounds = REC_RW'(n);
        return 32'(r);
    endfunction

    // One clock: drive inputs, step past the rising edge
    task automatic cyc(input logic i, input logic [1:0] m, input logic [1:0] p, input logic rdy);
        inizia   = i;
        manche   = m;
        partita  = p;
        rd_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Start strobe, then n valid rounds, the last one carrying the result
    task automatic play_match(input logic [1:0] code, input int n, input logic last_rdy);
        cyc(1'b1, 2'b00, 2'b00, 1'b0);
        for (int k = 1; k < n; k++) cyc(1'b0, 2'b01, 2'b00, 1'b0);
        cyc(1'b0, 2'b01, code, last_rdy);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_p1"},       32'(wins_p1), 32'd0);
        check_eq({tag, "_p2"},       32'(wins_p2), 32'd0);
        check_eq({tag, "_ties"},     32'(ties), 32'd0);
        check_eq({tag, "_active"},   32'(match_active), 32'd0);
        check_eq({tag, "_valid"},    32'(rd_valid), 32'd0);
        check_eq({tag, "_data"},     32'(rd_data), 32'd0);
        check_eq({tag, "_ovf"},      32'(overflow), 32'd0);
        check_eq({tag, "_slen"},     32'(streak_len), 32'd0);
        check_eq({tag, "_swho"},     32'(streak_who), 32'd0);
    endtask

    initial begin
        rst = 1'b1; inizia = 1'b0; manche = 2'b00; partita = 2'b00; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst0");
        rst = 1'b0;

        // IDLE ignores game outputs
        cyc(1'b0, 2'b01, 2'b01, 1'b0);
        check_eq("idle_p1", 32'(wins_p1), 32'd0);
        check_eq("idle_valid", 32'(rd_valid), 32'd0);

        // Three rounds, P1 wins on the third
        cyc(1'b1, 2'b00, 2'b00, 1'b0);
        check_eq("m1_act_pre", 32'(match_active), 32'd0);
        cyc(1'b0, 2'b01, 2'b00, 1'b0);
        check_eq("m1_act", 32'(match_active), 32'd1);
        cyc(1'b0, 2'b01, 2'b00, 1'b0);
        check_eq("m1_p1_pre", 32'(wins_p1), 32'd0);
        cyc(1'b0, 2'b01, 2'b01, 1'b0);
        check_eq("m1_p1", 32'(wins_p1), 32'd1);
        check_eq("m1_valid", 32'(rd_valid), 32'd1);
        check_eq("m1_data", 32'(rd_data), rec(P1, 3));
        check_eq("m1_act_end", 32'(match_active), 32'd0);
        cyc(1'b0, 2'b00, 2'b00, 1'b0);
        check_eq("m1_hold", 32'(rd_data), rec(P1, 3));
        cyc(1'b0, 2'b00, 2'b00, 1'b1);
        check_eq("m1_pop", 32'(rd_valid), 32'd0);

        // Invalid rounds interleaved: only two valid rounds count
        cyc(1'b1, 2'b00, 2'b00, 1'b0);
        cyc(1'b0, 2'b10, 2'b00, 1'b0);
        cyc(1'b0, 2'b00, 2'b00, 1'b0);
        cyc(1'b0, 2'b00, 2'b00, 1'b0);
        cyc(1'b0, 2'b10, 2'b10, 1'b0);
        check_eq("m2_p2", 32'(wins_p2), 32'd1);
        check_eq("m2_data", 32'(rd_data), rec(P2, 2));
        cyc(1'b0, 2'b00, 2'b00, 1'b1);

        // Match ends in the start cycle itself
        cyc(1'b1, 2'b00, 2'b00, 1'b0);
        cyc(1'b0, 2'b11, 2'b11, 1'b0);
        check_eq("m3_ties", 32'(ties), 32'd1);
        check_eq("m3_data", 32'(rd_data), rec(DRAW, 1));
        check_eq("m3_act", 32'(match_active), 32'd0);
        cyc(1'b0, 2'b00, 2'b00, 1'b1);
        cyc(1'b1, 2'b00, 2'b00, 1'b0);
        cyc(1'b0, 2'b00, 2'b01, 1'b0);
        check_eq("m4_p1", 32'(wins_p1), 32'd2);
        check_eq("m4_data", 32'(rd_data), rec(P1, 0));
        cyc(1'b0, 2'b00, 2'b00, 1'b1);

        // DONE ignores game outputs
        cyc(1'b0, 2'b10, 2'b10, 1'b0);
        check_eq("done_p2", 32'(wins_p2), 32'd1);
        check_eq("done_valid", 32'(rd_valid), 32'd0);

        // Round counter saturates at 31
        play_match(2'b10, 35, 1'b0);
        check_eq("sat_data", 32'(rd_data), rec(P2, 31));
        check_eq("sat_p2", 32'(wins_p2), 32'd2);
        cyc(1'b0, 2'b00, 2'b00, 1'b1);

        // Five matches into a depth-4 FIFO with no reads
        for (int i = 1; i <= 5; i++) begin
            play_match(2'b01, i, 1'b0);
            if (i == 4) check_eq("ovf_at4", 32'(overflow), 32'd0);
        end
        check_eq("ovf_set", 32'(overflow), 32'd1);
        check_eq("ovf_p1", 32'(wins_p1), 32'd7);
        for (int i = 1; i <= 4; i++) begin
            check_eq($sformatf("drain%0d", i), 32'(rd_data), rec(P1, i));
            cyc(1'b0, 2'b00, 2'b00, 1'b1);
        end
        check_eq("drain_empty", 32'(rd_valid), 32'd0);
        cyc(1'b0, 2'b00, 2'b00, 1'b1);
        check_eq("pop_empty", 32'(rd_valid), 32'd0);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);

        // Asynchronous reset, no clock edge needed
        rst = 1'b1;
        #1;
        check_reset("arst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full FIFO with push and pop together
        for (int i = 1; i <= 4; i++) play_match(2'b01, i, 1'b0);
        play_match(2'b01, 5, 1'b1);
        check_eq("fp_ovf", 32'(overflow), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            check_eq($sformatf("fp_drain%0d", i), 32'(rd_data), rec(P1, i));
            cyc(1'b0, 2'b00, 2'b00, 1'b1);
        end
        check_eq("fp_empty", 32'(rd_valid), 32'd0);

        // Reset in the middle of a match
        play_match(2'b10, 1, 1'b0);
        cyc(1'b1, 2'b00, 2'b00, 1'b0);
        cyc(1'b0, 2'b01, 2'b00, 1'b0);
        cyc(1'b0, 2'b01, 2'b00, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("mrst");
        rst = 1'b0;
        play_match(2'b01, 2, 1'b0);
        check_eq("mrst_data", 32'(rd_data), rec(P1, 2));
        check_eq("mrst_p1", 32'(wins_p1), 32'd1);

        // Streak: P2, P2, then a draw
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        play_match(2'b10, 1, 1'b1);
        play_match(2'b10, 1, 1'b1);
`ifdef MORRA_SCORE_STREAK_EN
        check_eq("stk_len", 32'(streak_len), 32'd2);
        check_eq("stk_who", 32'(streak_who), 32'd2);
`else
        check_eq("stk_len_off", 32'(streak_len), 32'd0);
        check_eq("stk_who_off", 32'(streak_who), 32'd0);
`endif
        play_match(2'b11, 1, 1'b1);
        check_eq("stk_draw_len", 32'(streak_len), 32'd0);
        check_eq("stk_draw_who", 32'(streak_who), 32'd0);
        check_eq("stk_ties", 32'(ties), 32'd1);
        check_eq("stk_p2", 32'(wins_p2), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morra_scoreboard.md
# morra_scoreboard

Downstream consumer of the `MorraCinese` game FSMD. It samples the per-round result `manche` and the match result `partita` every clock, and tracks each match's round count. It keeps saturating match-level tallies and queues one record per completed match in a small FIFO, read out through a valid/ready handshake. It sits between the game core and any display or logging stage.

## Interface
Parameters:
- `CW`, 8: width of match tallies and the streak counter.
- `RW`, 5: width of the per-match round counter.
- `DEPTH`, 4: result FIFO depth; power of two, at least 2.

Ports:
- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inizia`  in  1  same signal that drives the game's `inizia`.
- `manche`  in  2  game round output.
- `partita`  in  2  game match output.
- `wins_p1`, `wins_p2`, `ties`  out  CW  completed-match tallies.
- `match_active`  out  1  high while in PLAY.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_data`  out  RW+2  head record: {partita code[1:0], rounds[RW-1:0]}.
- `rd_ready`  in  1  consumer accepts the head record.
- `overflow`  out  1  sticky; a record was dropped.
- `streak_len`  out  CW  consecutive match wins; present only with the macro.
- `streak_who`  out  2  owner of the streak; present only with the macro.

## Operation
- Codes for `manche` and `partita`: 00 is invalid/ongoing, 01 is player 1, 10 is player 2, 11 is draw.
- Alignment:
  - `inizia` is registered once as `inizia_q`.
  - `inizia_q` lines up with the `manche`/`partita` produced by the game cycle in which `inizia` was applied.
  - All decisions below use `inizia_q`.
- IDLE (the reset state):
  - `manche` and `partita` are ignored.
  - `inizia_q`=1 moves to PLAY.
- PLAY:
  - A round is valid when `manche` != 00.
  - Each valid round increments `rounds`. `rounds` saturates at 2^RW-1.
  - When `partita` != 00:
    - Push {`partita`, `rounds` including this round}.
    - Increment the tally for `partita`: 01 goes to `wins_p1`, 10 to `wins_p2`, 11 to `ties`. Tallies saturate at 2^CW-1.
    - Move to DONE.
- DONE: `manche` and `partita` are ignored until `inizia_q`=1.
- When `inizia_q`=1 in any state:
  - `rounds` := (`manche` != 00) ? 1 : 0.
  - Move to PLAY.
  - If `partita` != 00 in the same cycle, the end-of-match handling applies in that same cycle, using `rounds`=1 or 0.
- FIFO:
  - Push on match end.
  - Pop when `rd_valid` && `rd_ready`.
  - Push while full with no pop drops the new record and sets `overflow`. `overflow` clears only on `rst`.
  - Push while full with a simultaneous pop is accepted, and `overflow` is not set.
  - Pop while empty has no effect.
- Counter wrap is forbidden; every counter saturates.

## Timing
- Reset values:
  - State IDLE; `inizia_q`=0; `rounds`=0.
  - All tallies 0; `match_active`=0; `rd_valid`=0; `rd_data`=0.
  - `overflow`=0; `streak_len`=0; `streak_who`=00.
- Tallies and streak update on the edge that samples the ending `partita`. They are visible immediately after that edge.
- Push takes effect on that same edge. `rd_valid` rises after it, so there is 1 cycle of latency from sampling to a readable record.
- `rd_data` is the registered FIFO head. It is stable while `rd_valid`=1 and `rd_ready`=0.
- `rst` asserted mid-match discards the in-progress match and all FIFO contents.

## Configuration
- `MORRA_SCORE_STREAK_EN` defined:
  - On each match end with code 01 or 10, if the code equals `streak_who`, `streak_len`++ (saturating).
  - Otherwise `streak_who` := code and `streak_len` := 1.
  - A draw (11) sets `streak_len`=0 and `streak_who`=00.
- Not defined: the streak logic is removed, and `streak_len`/`streak_who` are driven constant 0.

## Structure
- `morra_pkg` holds:
  - the `manche`/`partita` code enum (NONE, P1, P2, DRAW);
  - the state enum (IDLE, PLAY, DONE);
  - the record struct typedef.
- One sub-module, `morra_result_fifo`: a parameterised synchronous FIFO with push, pop, full, empty and registered head.
- Tallies, alignment and the FSM stay in `morra_scoreboard`.

## Test plan
- Reset, then `inizia`=1 followed by 3 rounds with `manche`=01, the last carrying `partita`=01:
  - `wins_p1`=1;
  - `rd_valid`=1 one cycle later;
  - `rd_data`={01, 3}.
- Rounds with `manche`=00 interleaved with valid rounds: only the valid rounds are counted, giving `rd_data` rounds=2 for a match with 2 valid rounds.
- Five completed matches with `rd_ready`=0 and DEPTH=4:
  - 4 records held;
  - `overflow`=1;
  - the fifth record is absent on drain.
- FIFO full, with push and `rd_ready`=1 in the same cycle: no overflow, and the count stays at 4.
- `partita`=10 twice, then 11, with the macro defined:
  - after the second match, `streak_len`=2 and `streak_who`=10;
  - after the draw, `streak_len`=0 and `ties`=1.
- `rst` pulsed mid-match: all outputs return to their reset values, and a following match records rounds starting from 1.
